// File: rtl/mdc_pkg.sv
// Shared definitions for the multiply/divide issue controller: op classes,
// FSM state encoding and default RUN latencies.
package mdc_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdc_state_e;

  localparam int unsigned MULT_LAT_DEF = 5;
  localparam int unsigned DIV_LAT_DEF  = 10;

endpackage

// File: rtl/mdc_lat_counter.sv
// Loadable 4-bit down counter that times an MDU operation; term flags the
// last RUN cycle (count == 1).
module mdc_lat_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       clear,
  input  logic       dec,
  output logic       term
);

  logic [3:0] cnt_d;
  logic [3:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = 4'd0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term = (cnt_q == 4'd1);

endmodule

// File: rtl/md_issue_ctrl.sv
// EX-stage multiply/divide sequencing: issues MDU strobes, times completion,
// stalls HI/LO accesses in flight and cancels a flushed youngest MD write.
// Optional feature: MDC_DIVZERO_SKIP_EN (div/divu by zero skips the MDU).
module md_issue_ctrl
  import mdc_pkg::*;
#(
  parameter int unsigned MULT_LAT = MULT_LAT_DEF,
  parameter int unsigned DIV_LAT  = DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        e_valid,
  input  logic [3:0]  e_op,
  input  logic [31:0] e_rt,
  input  logic        m_flush,
  output logic        md_start,
  output logic [3:0]  md_op,
  output logic        md_wr_hi,
  output logic        md_wr_lo,
  output logic        md_done,
  output logic        md_cancel,
  output logic        stall,
  output logic        busy
);

  mdc_state_e state_q;
  mdc_state_e state_d;
  logic       fresh_q;
  logic       fresh_d;
  logic       is_md;
  logic       is_arith;
  logic       is_div;
  logic       div_zero;
  logic       cnt_term;
  logic [3:0] lat_sel;

  assign is_md    = e_valid && (e_op >= OP_MULT) && (e_op <= OP_MTLO);
  assign is_arith = (e_op >= OP_MULT) && (e_op <= OP_DIVU);
  assign is_div   = (e_op == OP_DIV) || (e_op == OP_DIVU);
  assign lat_sel  = is_div ? 4'(DIV_LAT) : 4'(MULT_LAT);

`ifdef MDC_DIVZERO_SKIP_EN
  assign div_zero = is_div && (e_rt == 32'd0);
`else
  logic unused_rt;
  assign unused_rt = ^e_rt;
  assign div_zero  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      fresh_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fresh_q <= fresh_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (md_start) state_d = ST_RUN;
      ST_RUN:  if (md_cancel || cnt_term) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Everything is gated by reset so the MDU sees no strobes while it is held.
  always_comb begin
    md_start  = 1'b0;
    md_wr_hi  = 1'b0;
    md_wr_lo  = 1'b0;
    md_done   = 1'b0;
    md_cancel = 1'b0;
    stall     = 1'b0;
    busy      = 1'b0;
    md_op     = 4'd0;
    if (!reset) begin
      md_cancel = fresh_q && m_flush;
      busy      = (state_q == ST_RUN);
      case (state_q)
        ST_IDLE: begin
          if (!m_flush) begin
            md_start = is_md && is_arith && !div_zero;
            md_wr_hi = e_valid && (e_op == OP_MTHI);
            md_wr_lo = e_valid && (e_op == OP_MTLO);
          end
        end
        ST_RUN: begin
          stall   = is_md && !m_flush;
          md_done = cnt_term && !md_cancel;
        end
        default: ;
      endcase
      if (md_start || md_wr_hi || md_wr_lo) md_op = e_op;
    end
  end

  assign fresh_d = md_start || md_wr_hi || md_wr_lo;

  mdc_lat_counter u_lat_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (md_start),
    .load_val (lat_sel),
    .clear    (md_cancel),
    .dec      (state_q == ST_RUN),
    .term     (cnt_term)
  );

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Self-checking bench for md_issue_ctrl: cycle-timeline model plus directed
// scenarios with hand-computed counts.
module tb_md_issue_ctrl;
  import mdc_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        e_valid = 1'b0;
  logic [3:0]  e_op = 4'd0;
  logic [31:0] e_rt = 32'd0;
  logic        m_flush = 1'b0;
  logic        md_start, md_wr_hi, md_wr_lo, md_done, md_cancel, stall, busy;
  logic [3:0]  md_op;
  logic [10:0] act;

  int n_tests = 0;
  int n_fail  = 0;

  // model timeline, in cycle indices
  int cyc = 0;
  int run_start = 0;
  int run_end = -1;
  int last_issue = -100;

  // tallies for directed checks
  int k, n_start, n_done, n_cancel, n_stall, n_busy, n_wr_hi, n_wr_lo;
  int first_done_k, last_start_k;

  md_issue_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .e_valid   (e_valid),
    .e_op      (e_op),
    .e_rt      (e_rt),
    .m_flush   (m_flush),
    .md_start  (md_start),
    .md_op     (md_op),
    .md_wr_hi  (md_wr_hi),
    .md_wr_lo  (md_wr_lo),
    .md_done   (md_done),
    .md_cancel (md_cancel),
    .stall     (stall),
    .busy      (busy)
  );

  assign act = {md_start, md_wr_hi, md_wr_lo, md_done, md_cancel, stall, busy, md_op};

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, actual, expected);
    end
  endtask

  task automatic clearTally();
    k = 0; n_start = 0; n_done = 0; n_cancel = 0; n_stall = 0; n_busy = 0;
    n_wr_hi = 0; n_wr_lo = 0; first_done_k = -1; last_start_k = -1;
  endtask

  // One cycle: drive after the rising edge, tally outputs at the falling edge.
  task automatic applyStimulus(input logic rst, input logic v, input logic [3:0] op,
                               input logic [31:0] rt, input logic fl);
    @(posedge clk);
    #1;
    reset = rst; e_valid = v; e_op = op; e_rt = rt; m_flush = fl;
    @(negedge clk);
    if (md_start) begin n_start++; last_start_k = k; end
    if (md_done) begin n_done++; if (first_done_k < 0) first_done_k = k; end
    if (md_cancel) n_cancel++;
    if (stall) n_stall++;
    if (busy) n_busy++;
    if (md_wr_hi) n_wr_hi++;
    if (md_wr_lo) n_wr_lo++;
    k++;
  endtask

  task automatic waitIdle(input string name);
    logic ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b0, 1'b0, OP_NONE, 32'd0, 1'b0);
      if (!busy) begin ok = 1'b1; break; end
    end
    checkOutput(name, ok, 1'b1);
  endtask

  task automatic waitNoStall(input string name, input logic [3:0] op, output int iters);
    logic ok = 1'b0;
    iters = 0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b0, 1'b1, op, 32'd3, 1'b0);
      iters++;
      if (!stall) begin ok = 1'b1; break; end
    end
    checkOutput(name, ok, 1'b1);
  endtask

  // Model: an op issued in cycle T occupies T+1..T+lat and completes in T+lat;
  // a flush one cycle after an unflushed issue cancels it.
  always @(negedge clk) begin : compare
    logic in_run, is_md_m, arith, skip, cancel_m, start_m, whi, wlo, done_m;
    logic [10:0] exp_v;
    if (reset) begin
      checkOutput("outputs in reset", {21'd0, act}, 32'd0);
      run_start = 0; run_end = -1; last_issue = -100;
    end else begin
      in_run   = (cyc >= run_start) && (cyc <= run_end);
      is_md_m  = e_valid && (e_op >= 4'd1) && (e_op <= 4'd8);
      arith    = (e_op >= 4'd1) && (e_op <= 4'd4);
      skip     = 1'b0;
`ifdef MDC_DIVZERO_SKIP_EN
      skip     = ((e_op == 4'd3) || (e_op == 4'd4)) && (e_rt == 32'd0);
`endif
      cancel_m = m_flush && (last_issue == cyc - 1);
      start_m  = !in_run && is_md_m && arith && !m_flush && !skip;
      whi      = !in_run && e_valid && (e_op == 4'd7) && !m_flush;
      wlo      = !in_run && e_valid && (e_op == 4'd8) && !m_flush;
      done_m   = in_run && (cyc == run_end) && !cancel_m;
      exp_v = {start_m, whi, wlo, done_m, cancel_m, in_run && is_md_m && !m_flush, in_run,
               (start_m || whi || wlo) ? e_op : 4'd0};
      checkOutput("cycle outputs", {21'd0, act}, {21'd0, exp_v});
      if (cancel_m && in_run) run_end = cyc;
      if (start_m) begin
        run_start = cyc + 1;
        run_end   = cyc + (((e_op == 4'd3) || (e_op == 4'd4)) ? 10 : 5);
      end
      if (start_m || whi || wlo) last_issue = cyc;
    end
    cyc++;
  end

  initial begin : stimulus
    int iters;

    // reset held two cycles with a mult presented, then released idle
    clearTally();
    applyStimulus(1'b1, 1'b1, OP_MULT, 32'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, OP_MULT, 32'd0, 1'b0);
    checkOutput("reset start count", n_start, 0);
    checkOutput("reset busy count", n_busy, 0);
    applyStimulus(1'b0, 1'b0, OP_NONE, 32'd0, 1'b0);
    checkOutput("post-reset outputs", {21'd0, act}, 32'd0);
    applyStimulus(1'b0, 1'b0, OP_NONE, 32'd0, 1'b0);

    // mult then mflo waiting on it
    clearTally();
    applyStimulus(1'b0, 1'b1, OP_MULT, 32'd9, 1'b0);
    waitNoStall("mflo wait", OP_MFLO, iters);
    checkOutput("mult start count", n_start, 1);
    checkOutput("mult stall cycles", n_stall, 5);
    checkOutput("mult done count", n_done, 1);
    checkOutput("mult done cycle", first_done_k, 5);
    checkOutput("mflo proceed cycle", iters, 6);

    // div then divu back-to-back
    clearTally();
    applyStimulus(1'b0, 1'b1, OP_DIV, 32'd7, 1'b0);
    waitNoStall("divu wait", OP_DIVU, iters);
    waitIdle("divu drain");
    checkOutput("div start count", n_start, 2);
    checkOutput("div done count", n_done, 2);
    checkOutput("div busy cycles", n_busy, 20);
    checkOutput("divu issue gap", last_start_k - first_done_k, 1);

    // mult flushed the very next cycle
    clearTally();
    applyStimulus(1'b0, 1'b1, OP_MULTU, 32'd2, 1'b0);
    applyStimulus(1'b0, 1'b0, OP_NONE, 32'd0, 1'b1);
    checkOutput("cancel pulse", md_cancel, 1'b1);
    applyStimulus(1'b0, 1'b0, OP_NONE, 32'd0, 1'b0);
    checkOutput("busy after cancel", busy, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, OP_NONE, 32'd0, 1'b0);
    checkOutput("cancel count", n_cancel, 1);
    checkOutput("cancelled done count", n_done, 0);
    checkOutput("cancelled busy cycles", n_busy, 1);

    // mthi flushed next cycle, mtlo flushed two cycles later
    clearTally();
    applyStimulus(1'b0, 1'b1, OP_MTHI, 32'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, OP_NONE, 32'd0, 1'b1);
    applyStimulus(1'b0, 1'b0, OP_NONE, 32'd0, 1'b0);
    checkOutput("mthi write count", n_wr_hi, 1);
    checkOutput("mthi cancel count", n_cancel, 1);
    clearTally();
    applyStimulus(1'b0, 1'b1, OP_MTLO, 32'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, OP_NONE, 32'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, OP_NONE, 32'd0, 1'b1);
    checkOutput("mtlo write count", n_wr_lo, 1);
    checkOutput("late flush cancel count", n_cancel, 0);
    clearTally();
    applyStimulus(1'b0, 1'b1, OP_MTHI, 32'd0, 1'b1);
    applyStimulus(1'b0, 1'b1, OP_MULT, 32'd0, 1'b1);
    applyStimulus(1'b0, 1'b0, OP_NONE, 32'd0, 1'b0);
    checkOutput("squashed mthi count", n_wr_hi, 0);
    checkOutput("squashed mult count", n_start, 0);

    // flush of an older instruction mid-run: no cancel, stall dropped once
    clearTally();
    applyStimulus(1'b0, 1'b1, OP_MULT, 32'd4, 1'b0);
    applyStimulus(1'b0, 1'b1, OP_MFHI, 32'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, OP_MFHI, 32'd0, 1'b1);
    waitNoStall("mfhi wait", OP_MFHI, iters);
    checkOutput("mid-run cancel count", n_cancel, 0);
    checkOutput("mid-run done count", n_done, 1);
    checkOutput("mid-run stall cycles", n_stall, 4);

    // op codes 9..15 and invalid ops issue nothing
    clearTally();
    applyStimulus(1'b0, 1'b1, 4'd9, 32'd1, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'd15, 32'd1, 1'b0);
    applyStimulus(1'b0, 1'b0, OP_MULT, 32'd1, 1'b0);
    applyStimulus(1'b0, 1'b0, OP_NONE, 32'd0, 1'b0);
    checkOutput("junk op starts", n_start, 0);
    checkOutput("junk op busy", n_busy, 0);

    // divide by zero
    clearTally();
    applyStimulus(1'b0, 1'b1, OP_DIV, 32'd0, 1'b0);
    waitIdle("div zero drain");
`ifdef MDC_DIVZERO_SKIP_EN
    checkOutput("div zero start count", n_start, 0);
    checkOutput("div zero busy cycles", n_busy, 0);
`else
    checkOutput("div zero start count", n_start, 1);
    checkOutput("div zero busy cycles", n_busy, 10);
`endif

    applyStimulus(1'b0, 1'b0, OP_NONE, 32'd0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/md_issue_ctrl.md
# md_issue_ctrl

Sequencing controller for the multiply/divide unit, placed in the EX stage between the decoded EX-stage instruction and the MDU. Issues start/write strobes to the MDU and owns the latency count, so completion timing is decided here. Raises the pipeline stall for any HI/LO access while an operation is in flight. Cancels the youngest MD write when the exception logic flushes it from MEM.

## Interface
Parameters:
- MULT_LAT, 5: cycles spent in RUN for mult/multu; legal range 1..15.
- DIV_LAT, 10: cycles spent in RUN for div/divu; legal range 1..15.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- e_valid  in  1  EX-stage instruction is valid.
- e_op  in  4  MD op class: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo; 9..15 treated as none.
- e_rt  in  32  forwarded divisor operand.
- m_flush  in  1  the instruction in MEM, and everything younger, is killed this cycle.
- md_start  out  1  one-cycle start strobe to the MDU.
- md_op  out  4  e_op, passed through while md_start, md_wr_hi or md_wr_lo is high; else 0.
- md_wr_hi, md_wr_lo  out  1  one-cycle mthi/mtlo write strobes.
- md_done  out  1  one-cycle pulse; the MDU commits its result to HI/LO on this edge.
- md_cancel  out  1  one-cycle pulse; the MDU restores the HI/LO it saved at issue.
- stall  out  1  freeze IF/ID/EX.
- busy  out  1  state == RUN.

## Operation
- States: IDLE, RUN.
- Internal registers:
  - cnt: 4-bit down counter.
  - fresh: 1 bit. Set on any issue (start or mthi/mtlo write) when m_flush is low. Cleared on the next cycle.
- Definitions:
  - is_md = e_valid and e_op in 1..8.
  - is_arith = e_op in 1..4.
- IDLE:
  - When is_md, is_arith and not m_flush: assert md_start, load cnt with MULT_LAT (op 1, 2) or DIV_LAT (op 3, 4), go to RUN.
  - Op 7 or 8 with e_valid and not m_flush: assert md_wr_hi or md_wr_lo. State stays IDLE.
  - Ops 5 and 6 need no strobe.
- RUN:
  - stall = is_md and not m_flush.
  - cnt decrements each cycle.
  - In the cycle where cnt == 1: assert md_done and go to IDLE. stall is still asserted in this cycle, so mfhi/mflo reads next cycle see committed HI/LO.
- Cancel:
  - If fresh and m_flush in the same cycle, assert md_cancel.
  - If in RUN, go to IDLE, clear cnt, and suppress md_done.
  - m_flush with fresh low does not cancel: the op has already passed MEM.
- m_flush always squashes the EX op: no strobe, and stall is forced to 0.
- Reset: state IDLE, cnt 0, fresh 0. All outputs 0 on the cycle after reset is sampled, and they stay 0 while reset is high.

## Timing
- md_start, md_wr_*, md_cancel, md_done and stall are combinational from state, cnt, fresh and the inputs. The MDU samples them at the next rising edge.
- mult issued in cycle T: RUN spans T+1..T+MULT_LAT, md_done is high in T+MULT_LAT, IDLE from T+MULT_LAT+1.
- mfhi in EX at T+1: stalls MULT_LAT cycles and executes in T+MULT_LAT+1.
- Back-to-back arithmetic ops: the second one stalls, then issues in the first IDLE cycle (zero bubble after md_done).
- Flush at T+1 (fresh): md_cancel at T+1, IDLE at T+2, no md_done.

## Configuration
- MDC_DIVZERO_SKIP_EN defined:
  - div/divu with e_rt == 0 does not enter RUN and asserts no md_start. HI/LO are unchanged.
  - No stall results, and mfhi/mflo proceed immediately.
  - fresh is not set.
- MDC_DIVZERO_SKIP_EN undefined: a zero divisor is treated like any other div (DIV_LAT cycles, MDU-defined result).

## Structure
- Package mdc_pkg holds:
  - the MD op-class encoding constants (0..8);
  - the state encoding;
  - default MULT_LAT and DIV_LAT.
- Sub-module mdc_lat_counter: loadable 4-bit down counter with load, clear and a terminal (==1) flag. It is instantiated once.

## Test plan
- Reset held for 2 cycles, then released with e_valid=0: all outputs 0, busy 0.
- mult issued, then mflo in EX: md_start 1 cycle; stall exactly 5 cycles; md_done in the 5th; mflo proceeds in the 6th.
- div then divu back-to-back, DIV_LAT=10: second md_start exactly 1 cycle after first md_done; 20 busy cycles total.
- mult issued, m_flush the next cycle: md_cancel 1 cycle, busy drops the following cycle, md_done never asserted.
- mthi, then m_flush the next cycle: md_wr_hi 1 cycle, then md_cancel 1 cycle. Repeat with m_flush 2 cycles later: no md_cancel.
- div with e_rt=0: with MDC_DIVZERO_SKIP_EN, no md_start and no stall; without it, 10-cycle RUN.
